// File: rtl/ahb_bridge_pkg.sv
// Shared encodings for the AHB-to-APB bridge: HTRANS, HRESP and the slave
// front-end response FSM states.
package ahb_bridge_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_ERR1,
    ST_ERR2
  } state_t;
endpackage

// File: rtl/ahb_addr_reg.sv
// Address-phase capture register. Loads on an accepted beat; on other
// HREADY-high edges only the transfer type collapses to IDLE.
module ahb_addr_reg
  import ahb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready_in,
  input  logic              accept,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        trans,
  input  logic              write,
  input  logic [2:0]        size,
  input  logic [2:0]        burst,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [1:0]        reg_trans,
  output logic              reg_write,
  output logic [2:0]        reg_size,
  output logic [2:0]        reg_burst
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_addr  <= '0;
      reg_trans <= HTRANS_IDLE;
      reg_write <= 1'b0;
      reg_size  <= '0;
      reg_burst <= '0;
    end else if (accept) begin
      reg_addr  <= addr;
      reg_trans <= trans;
      reg_write <= write;
      reg_size  <= size;
      reg_burst <= burst;
    end else if (ready_in) begin
      reg_trans <= HTRANS_IDLE;
    end
  end
endmodule

// File: rtl/ahb_slave_frontend.sv
// AHB slave front end: captures the address phase, sequences one APB
// transfer per NONSEQ/SEQ beat and produces the two-cycle AHB ERROR response.
module ahb_slave_frontend
  import ahb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              h_clk,
  input  logic              h_reset,
  input  logic              h_sel,
  input  logic              h_ready_in,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [1:0]        h_trans,
  input  logic              h_write,
  input  logic [2:0]        h_size,
  input  logic [2:0]        h_burst,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              burst_err,
  input  logic              apb_done,
  input  logic              apb_err,
  input  logic [DATA_W-1:0] apb_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [1:0]        reg_trans,
  output logic              reg_write,
  output logic [2:0]        reg_size,
  output logic [2:0]        reg_burst,
  output logic              apb_req,
  output logic [DATA_W-1:0] apb_wdata,
  output logic              h_ready_out,
  output logic              h_resp,
  output logic [DATA_W-1:0] h_rdata
);
  state_t state;
  logic   accept;
  logic   start;
  state_t accept_next;

  // HREADY must rise in the same cycle the APB side completes, so it is
  // decoded from the state rather than registered.
  always_comb begin
    h_ready_out = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: h_ready_out = 1'b1;
      ST_XFER:          h_ready_out = apb_done & ~apb_err;
      default:          h_ready_out = 1'b0;
    endcase
  end

  assign apb_req     = (state == ST_XFER);
  assign h_resp      = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign accept      = h_sel & h_ready_in & h_ready_out;
  assign start       = accept & h_trans[1];
  assign accept_next = !start ? ST_IDLE : (burst_err ? ST_ERR1 : ST_SETUP);

  ahb_addr_reg #(.ADDR_W(ADDR_W)) u_addr_reg (
    .clk       (h_clk),
    .rst       (h_reset),
    .ready_in  (h_ready_in),
    .accept    (accept),
    .addr      (h_addr),
    .trans     (h_trans),
    .write     (h_write),
    .size      (h_size),
    .burst     (h_burst),
    .reg_addr  (reg_addr),
    .reg_trans (reg_trans),
    .reg_write (reg_write),
    .reg_size  (reg_size),
    .reg_burst (reg_burst)
  );

  always_ff @(posedge h_clk or posedge h_reset) begin
    if (h_reset) begin
      state     <= ST_IDLE;
      apb_wdata <= '0;
      h_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: state <= accept_next;
        ST_SETUP: begin
          apb_wdata <= h_wdata;
          state     <= ST_XFER;
        end
        ST_XFER: begin
          if (apb_done) begin
            if (apb_err) begin
              state <= ST_ERR1;
            end else begin
              h_rdata <= apb_rdata;
              state   <= accept_next;
            end
          end
        end
        ST_ERR1:  state <= ST_ERR2;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ahb_slave_frontend.md
AHB_SLAVE_FRONTEND -- requirements
Module: ahb_slave_frontend

Interface
REQ-001 Parameter ADDR_W, default 32, sets the width of the AHB address and of reg_addr.
REQ-002 Parameter DATA_W, default 32, sets the width of the AHB and APB data buses.
REQ-003 h_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 h_reset  in  1  asynchronous, active-high reset.
REQ-005 h_sel, h_ready_in  in  1 each  slave select and bus-wide HREADY.
REQ-006 h_addr  in  ADDR_W; h_trans in 2; h_write in 1; h_size in 3; h_burst in 3  AHB address-phase signals.
REQ-007 h_wdata  in  DATA_W  AHB write data, valid in the data phase.
REQ-008 burst_err  in  1  combinational verdict from the burst error decoder on the incoming beat.
REQ-009 apb_done, apb_err  in  1 each; apb_rdata  in  DATA_W  completion, error and read data from the APB master side.
REQ-010 reg_addr ADDR_W, reg_trans 2, reg_write 1, reg_size 3, reg_burst 3  out  registered address-phase copy, fed back to the decoder.
REQ-011 apb_req  out  1; apb_wdata  out  DATA_W  transfer request and held write data.
REQ-012 h_ready_out  out  1; h_resp  out  1 (0 OKAY, 1 ERROR); h_rdata  out  DATA_W  AHB slave response.

Function
REQ-013 An accept happens on any edge where h_sel=1, h_ready_in=1 and h_ready_out=1 in that cycle.
REQ-014 On an accept, all reg_* signals shall load the h_* values; on a non-accept edge where h_ready_in=1, reg_trans shall load IDLE (2'b00) and the other reg_* signals shall hold.
REQ-015 FSM states: IDLE, SETUP, XFER, ERR1, ERR2.
REQ-016 IDLE/ERR2, accept with h_trans NONSEQ/SEQ: burst_err=1 -> ERR1; else -> SETUP.
REQ-017 IDLE/ERR2, accept with h_trans IDLE/BUSY: -> IDLE with an OKAY response and no APB activity.
REQ-018 IDLE/ERR2, no accept: -> IDLE.
REQ-019 SETUP: apb_wdata <= h_wdata; h_ready_out=0; apb_req=0; -> XFER after exactly 1 cycle.
REQ-020 XFER: apb_req=1 and h_ready_out=0 until apb_done=1.
REQ-021 XFER with apb_done=1 and apb_err=1 -> ERR1; apb_err takes priority over success.
REQ-022 XFER with apb_done=1 and apb_err=0: h_ready_out=1 combinationally in that cycle; h_rdata <= apb_rdata.
REQ-023 Exit from XFER on success follows the IDLE accept rules of REQ-016 to REQ-018, so a back-to-back beat is pipelined.
REQ-024 ERR1: h_ready_out=0, h_resp=1; -> ERR2 after exactly 1 cycle.
REQ-025 ERR2: h_ready_out=1, h_resp=1; a transfer presented in this cycle is accepted normally, and a master-cancelled (IDLE) transfer is also legal.
REQ-026 h_resp=0 in IDLE, SETUP and XFER.
REQ-027 Response latency: write or read OKAY completes 2 + N cycles after accept (N = APB wait cycles, ≥0); error response is exactly 2 cycles.
REQ-028 apb_done or apb_err outside XFER shall be ignored.
REQ-029 apb_wdata shall hold its value from SETUP until the next SETUP.
REQ-030 h_sel=0 during an accept cycle produces no transfer, even when h_trans is nonzero.

Reset
REQ-031 While h_reset=1, state shall be IDLE.
REQ-032 While h_reset=1, reg_addr=0, reg_trans=IDLE, reg_write=0, reg_size=0 and reg_burst=0.
REQ-033 While h_reset=1, apb_req=0, apb_wdata=0, h_rdata=0, h_ready_out=1 and h_resp=0.
REQ-034 Assertion of h_reset mid-operation (SETUP, XFER or ERR1/ERR2) shall immediately deassert apb_req and drop any pending transfer, with no completion reported.

Structure
REQ-035 Shared package ahb_bridge_pkg shall hold the htrans encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11), the hresp constants and the FSM state enum.
REQ-036 The address-phase capture register (REQ-014) shall be the sub-module ahb_addr_reg.
REQ-037 The response FSM and data-path registers shall be in ahb_slave_frontend itself.

Verification
REQ-038 Single write: NONSEQ, addr 0x100, burst 0, apb_done one cycle after apb_req -> h_ready_out low for 2 cycles, then high with h_resp=0; apb_wdata = h_wdata.
REQ-039 INCR4 read at 0x200 with 0 APB wait states -> four OKAY beats; reg_addr steps 0x200, 0x204, 0x208, 0x20C; h_rdata matches apb_rdata on each beat.
REQ-040 burst_err=1 on the 2nd beat -> no apb_req for that beat; h_resp=1 with h_ready_out=0 then 1; the IDLE presented in ERR2 returns the FSM to IDLE.
REQ-041 apb_done=1 and apb_err=1 together in XFER -> two-cycle ERROR response; h_rdata unchanged.
REQ-042 h_reset pulsed during XFER with 3 wait cycles pending -> apb_req drops the same cycle; all outputs at reset values; the next NONSEQ completes normally.
REQ-043 BUSY beat inside an INCR burst, and h_sel=0 with h_trans=NONSEQ -> no apb_req; h_ready_out stays 1 with OKAY.
